mesh_frame_sequencer: RTL and testbench
=======================================

Name: mesh_frame_sequencer

Overview:
Sequencer that feeds the twobit_26x18_mesh from a narrow input stream and drains its result to a narrow output stream. Collects 26 row words (18 cells x 2 bits) into the 936-bit mesh input vector and holds it stable while the mesh settles. Captures the 468-bit mesh output into a shadow register and emits it row by row with valid/ready handshakes. Sits between the row-streaming front end and the mesh datapath.

Parameters:
ROWS, 26, mesh rows; number of words per input and output frame
COLS, 18, cells per row
CELL_W, 2, input bits per cell; input word width = COLS*CELL_W = 36
LATENCY, 4, mesh settle cycles between the last input word and capture; must be >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  input row word valid
s_ready  out  1  sequencer accepts an input row word
s_data  in  COLS*CELL_W  input row word; word r maps to mesh_inp[r*36 +: 36]
mesh_inp  out  ROWS*COLS*CELL_W  registered vector to mesh .inp (936 bits)
mesh_out  in  ROWS*COLS  mesh .out result (468 bits)
m_valid  out  1  output row word valid
m_ready  in  1  downstream accepts output word
m_data  out  COLS  output row word r = shadow[r*18 +: 18]
m_last  out  1  high with m_valid on row ROWS-1
busy  out  1  high unless in LOAD with zero rows loaded
frame_done  out  1  one-cycle pulse on the final output handshake

Behaviour:
- Reset (async, rst=1): state=LOAD, load_cnt=0, drain_cnt=0, settle_cnt=0, mesh_inp=0, shadow=0, m_valid=0, m_last=0, frame_done=0, s_ready=0 while rst high.
- States: LOAD, SETTLE, CAPTURE, DRAIN.
- LOAD: s_ready=1. On s_valid&s_ready write s_data to mesh_inp row load_cnt, increment load_cnt. Handshake with load_cnt=ROWS-1 -> load_cnt=0, settle_cnt=0, go SETTLE. Gaps in s_valid allowed; no timeout.
- SETTLE: s_ready=0, mesh_inp held constant; settle_cnt increments each cycle; after exactly LATENCY cycles -> CAPTURE.
- CAPTURE: one cycle; at its closing edge shadow<=mesh_out, drain_cnt=0, go DRAIN.
- m_valid rises exactly LATENCY+1 edges after the edge that accepted the last input word.
- DRAIN: m_valid=1, m_data=shadow row drain_cnt, m_last=(drain_cnt==ROWS-1). m_data/m_last stable while m_valid&!m_ready. On handshake increment drain_cnt; handshake on last row -> frame_done pulse next cycle, m_valid=0, go LOAD (or SETTLE, see option).
- mesh_inp is only written in LOAD (or DRAIN with option); never changes during SETTLE/CAPTURE.
- Counters are $clog2(ROWS) wide; no wrap beyond ROWS-1.
- rst mid-frame: all state discarded immediately, partial frame lost, no frame_done.

Optional Feature:
Macro MESH_SEQ_OVERLAP_EN.
- Defined: s_ready=1 also in DRAIN; next frame rows written into mesh_inp while shadow drains (safe, result already captured). At last output handshake: if load_cnt reached ROWS (tracked by full flag) go straight to SETTLE, else to LOAD keeping load_cnt. Simultaneous last-input and last-output handshake -> SETTLE.
- Not defined: s_ready=1 only in LOAD; input stalls during SETTLE/CAPTURE/DRAIN.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously; after release s_ready=1, busy=0.
- Single frame, s_data=row index replicated (word r = {18{r[1:0]}}), s_valid continuous, m_ready=1 -> mesh_inp[r*36+:36] matches, m_valid rises 5 edges after last accept (LATENCY=4), 26 words = reference-model mesh_out rows, m_last on word 25, frame_done one pulse.
- Backpressure: m_ready random 50% -> m_data/m_last unchanged while stalled; exactly 26 handshakes, order preserved.
- Input gaps: s_valid low 3 cycles between each word -> mesh_inp unchanged during gaps; SETTLE starts only after word 25.
- Reset during DRAIN at row 10 -> m_valid=0 immediately; next frame fully correct, no stale rows.
- MESH_SEQ_OVERLAP_EN: feed frame 2 during frame 1 drain with m_ready=0 first 30 cycles -> frame 2 enters SETTLE on frame 1 last handshake; both results correct; without macro s_ready=0 throughout DRAIN.

Source files
------------

// File: rtl/mesh_frame_sequencer.sv
// Row-stream sequencer around the 26x18 two-bit mesh: load, settle, capture, drain.
// Define MESH_SEQ_OVERLAP_EN to load the next frame while the current result drains.
module mesh_frame_sequencer #(
  parameter int ROWS    = 26,
  parameter int COLS    = 18,
  parameter int CELL_W  = 2,
  parameter int LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [COLS*CELL_W-1:0]      s_data,
  output logic [ROWS*COLS*CELL_W-1:0] mesh_inp,
  input  logic [ROWS*COLS-1:0]        mesh_out,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [COLS-1:0]             m_data,
  output logic                        m_last,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int W     = COLS*CELL_W;
  localparam int CNT_W = $clog2(ROWS);
  localparam int SET_W = $clog2(LATENCY+1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS-1);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(LATENCY-1);

  typedef enum logic [1:0] {LOAD, SETTLE, CAPTURE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [ROWS*W-1:0]    mesh_inp_q, mesh_inp_d;
  logic [ROWS*COLS-1:0] shadow_q, shadow_d;
  logic                 frame_done_q, frame_done_d;
  logic                 full_q, full_d;
  logic                 s_fire, m_fire, in_last, out_last;

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    settle_cnt_d = settle_cnt_q;
    mesh_inp_d   = mesh_inp_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    full_d       = full_q;
    m_valid      = state_q == DRAIN;
    m_last       = m_valid && drain_cnt_q == LAST_ROW;
    m_data       = shadow_q[drain_cnt_q*COLS +: COLS];
`ifdef MESH_SEQ_OVERLAP_EN
    s_ready = !rst && (state_q == LOAD ||
              (state_q == DRAIN && !full_q));
`else
    s_ready = !rst && state_q == LOAD;
`endif
    s_fire   = s_valid && s_ready;
    m_fire   = m_valid && m_ready;
    in_last  = s_fire && load_cnt_q == LAST_ROW;
    out_last = m_fire && m_last;

    if (s_fire) begin
      mesh_inp_d[load_cnt_q*W +: W] = s_data;
      load_cnt_d = in_last ? '0 : load_cnt_q + 1'b1;
    end

    unique case (state_q)
      LOAD: begin
        if (in_last) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == LAST_SET) state_d = CAPTURE;
        else settle_cnt_d = settle_cnt_q + 1'b1;
      end
      CAPTURE: begin
        shadow_d    = mesh_out;
        drain_cnt_d = '0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (in_last) full_d = 1'b1;
        if (m_fire) drain_cnt_d = drain_cnt_q + 1'b1;
        if (out_last) begin
          frame_done_d = 1'b1;
          drain_cnt_d  = '0;
          // a complete next frame already sits in mesh_inp
          if (full_q || in_last) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
            full_d       = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      load_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      settle_cnt_q <= '0;
      mesh_inp_q   <= '0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      mesh_inp_q   <= mesh_inp_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      full_q       <= full_d;
    end
  end

  assign mesh_inp   = mesh_inp_q;
  assign frame_done = frame_done_q;
  assign busy       = !(state_q == LOAD && load_cnt_q == '0);

endmodule

// File: tb/tb_mesh_frame_sequencer.sv
// Bench for mesh_frame_sequencer: table of frames, scoreboard of output rows,
// a delayed mesh model, plus reset and overlap corner sequences.
module tb_mesh_frame_sequencer;
  localparam int ROWS = 26;
  localparam int COLS = 18;
  localparam int CW   = 2;
  localparam int LAT  = 4;
  localparam int W    = COLS*CW;
  localparam int NI   = ROWS*W;
  localparam int NO   = ROWS*COLS;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [W-1:0]    s_data = '0;
  logic [NI-1:0]   mesh_inp;
  logic [NO-1:0]   mesh_out;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [COLS-1:0] m_data;
  logic            m_last;
  logic            busy;
  logic            frame_done;

  mesh_frame_sequencer dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mesh_inp(mesh_inp), .mesh_out(mesh_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [NO-1:0] mesh_fn(input logic [NI-1:0] v);
    logic [NO-1:0] o;
    o = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        o[r*COLS+c] = v[(r*COLS+c)*CW]
                    ^ v[(r*COLS+(c+1)%COLS)*CW+1]
                    ^ v[(((r+1)%ROWS)*COLS+c)*CW];
    return o;
  endfunction

  // mesh result only valid LAT edges after its input last changed
  logic [NI-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mesh_inp;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mesh_out = mesh_fn(pipe[LAT-1]);

  typedef struct {
    int pat;
    int gap;
    int rdy;
    int exp_hs;
  } vec_t;

  logic [W-1:0]  in_q[$];
  logic [COLS:0] exp_q[$];
  logic [COLS:0] stage_q[$];
  logic [NI-1:0] sent_vec;
  logic [COLS-1:0] prev_data;
  logic          prev_last;
  int  sent_n, cyc, trig, gap, gap_left, rdy_pct;
  int  hs_cnt, drain_sready;
  bit  wait_trig, seen_valid, fd_exp, prev_stall;
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [NI-1:0] act,
                           input logic [NI-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int r = 0; r < ROWS; r++)
        if (act[r*W +: W] !== exp[r*W +: W]) begin
          $display("FAIL %s row %0d: got %h want %h (cyc %0d)",
                   name, r, act[r*W +: W], exp[r*W +: W], cyc);
          break;
        end
    end
  endtask

  function automatic logic [W-1:0] gen_word(input int pat, input int r);
    logic [1:0]  rr;
    logic [63:0] t;
    rr = 2'(r);
    t  = {$urandom(), $urandom()};
    case (pat)
      0:       return {18{rr}};
      1:       return t[W-1:0];
      2:       return '1;
      default: return (r % 2 == 1) ? {18{2'b10}} : {18{2'b01}};
    endcase
  endfunction

  task automatic queue_frame(input int pat);
    for (int r = 0; r < ROWS; r++) in_q.push_back(gen_word(pat, r));
  endtask

  task automatic build_stage(input logic [NI-1:0] v);
    logic [NO-1:0] o;
    o = mesh_fn(v);
    stage_q.delete();
    for (int r = 0; r < ROWS; r++)
      stage_q.push_back({r == ROWS-1, o[r*COLS +: COLS]});
  endtask

  task automatic promote();
    exp_q = stage_q;
    stage_q.delete();
    trig = cyc;
    seen_valid = 1'b0;
  endtask

  // one clock: drive at negedge, sample 1ns later, then wait next negedge
  task automatic cycle();
    logic [COLS:0] e;
    if (gap_left > 0) begin
      s_valid = 1'b0;
      gap_left--;
    end else begin
      s_valid = in_q.size() > 0;
      s_data  = s_valid ? in_q[0] : '0;
    end
    m_ready = $urandom_range(99) < rdy_pct;
    #1;
    check_vec("mesh_inp", mesh_inp, sent_vec);
    if (fd_exp || frame_done) check("frame_done", frame_done, fd_exp);
    fd_exp = 1'b0;
    if (m_valid) begin
      if (exp_q.size() == 0) check("spurious_m_valid", 1, 0);
      else if (!seen_valid) begin
        check("m_valid_latency", cyc - trig, LAT + 2);
        seen_valid = 1'b1;
      end
      if (prev_stall)
        check("stall_hold", {m_last, m_data}, {prev_last, prev_data});
      if (s_ready) drain_sready++;
      prev_stall = !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        hs_cnt++;
        check("m_row", {m_last, m_data}, e);
        if (exp_q.size() == 0) begin
          fd_exp = 1'b1;
          if (wait_trig) begin
            promote();
            wait_trig = 1'b0;
          end
        end
      end
    end else begin
      if (prev_stall) check("valid_dropped", 0, 1);
      prev_stall = 1'b0;
    end
    if (s_valid && s_ready) begin
      sent_vec[sent_n*W +: W] = in_q.pop_front();
      gap_left = gap;
      if (sent_n == ROWS-1) begin
        sent_n = 0;
        build_stage(sent_vec);
        if (exp_q.size() == 0) promote();
        else wait_trig = 1'b1;
      end else begin
        sent_n++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0 || wait_trig || fd_exp)
           && n < budget) begin
      cycle();
      n++;
    end
    check(name, n < budget, 1);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check_vec("rst_mesh_inp", mesh_inp, '0);
    in_q.delete();
    exp_q.delete();
    stage_q.delete();
    sent_vec   = '0;
    sent_n     = 0;
    gap_left   = 0;
    wait_trig  = 1'b0;
    seen_valid = 1'b0;
    fd_exp     = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_busy", busy, 0);
    @(negedge clk);
    cyc++;
  endtask

  vec_t tbl [6];

  initial begin
    int n;
    tbl[0] = '{pat: 0, gap: 0, rdy: 100, exp_hs: ROWS};
    tbl[1] = '{pat: 1, gap: 0, rdy: 50,  exp_hs: ROWS};
    tbl[2] = '{pat: 1, gap: 3, rdy: 100, exp_hs: ROWS};
    tbl[3] = '{pat: 2, gap: 1, rdy: 30,  exp_hs: ROWS};
    tbl[4] = '{pat: 3, gap: 0, rdy: 100, exp_hs: ROWS};
    tbl[5] = '{pat: 1, gap: 2, rdy: 70,  exp_hs: ROWS};
    cyc = 0;
    trig = 0;
    gap = 0;
    rdy_pct = 100;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      gap     = tbl[i].gap;
      rdy_pct = tbl[i].rdy;
      hs_cnt  = 0;
      queue_frame(tbl[i].pat);
      run_until_idle("frame_in_budget", 2000);
      check("handshakes", hs_cnt, tbl[i].exp_hs);
    end

    // reset while draining row 10
    gap = 0;
    rdy_pct = 100;
    hs_cnt = 0;
    queue_frame(1);
    n = 0;
    while (hs_cnt < 10 && n < 200) begin
      cycle();
      n++;
    end
    check("reached_row10", hs_cnt, 10);
    do_reset();
    hs_cnt = 0;
    queue_frame(1);
    run_until_idle("after_rst_in_budget", 2000);
    check("after_rst_handshakes", hs_cnt, ROWS);

    // second frame offered while the first is stalled in drain
    hs_cnt = 0;
    rdy_pct = 0;
    queue_frame(1);
    n = 0;
    while (!seen_valid && n < 200) begin
      cycle();
      n++;
    end
    check("ovl_first_valid", seen_valid, 1);
    queue_frame(1);
    drain_sready = 0;
    for (int k = 0; k < 30; k++) cycle();
    rdy_pct = 100;
    run_until_idle("ovl_in_budget", 2000);
    check("ovl_handshakes", hs_cnt, 2*ROWS);
`ifdef MESH_SEQ_OVERLAP_EN
    check("drain_s_ready_seen", drain_sready > 0, 1);
`else
    check("drain_s_ready_cycles", drain_sready, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
